// File: rtl/mash_ddsm_pkg.sv
// Shared constants and helpers for the configurable MASH delta-sigma modulator.
package mash_ddsm_pkg;

    localparam int          MAX_ORDER_LIMIT = 4;
    localparam logic [14:0] LFSR_SEED       = 15'h0001;
    // Feedback taps of x^15 + x^14 + 1 (state bits 14 and 13).
    localparam logic [14:0] LFSR_TAPS       = 15'h6000;

    // Map a requested order into the legal range 1..max_order.
    function automatic logic [2:0] clamp_order(input logic [2:0] req, input int max_order);
        logic [2:0] max_v;
        max_v = 3'(max_order);
        if (req == 3'd0) begin
            clamp_order = 3'd1;
        end else if (req > max_v) begin
            clamp_order = max_v;
        end else begin
            clamp_order = req;
        end
    endfunction

    // Signed output width needed for a given MASH order.
    function automatic int out_width(input int order);
        return order + 1;
    endfunction

    // Noise-cancellation weight of carry tap j (j cycles old) of stage index k
    // (0-based): (-1)^j * C(k, j), i.e. the k-th backward difference.
    function automatic int ncf_coef(input int k, input int j);
        int mag;
        if (j > k) begin
            mag = 0;
        end else if ((j == 0) || (j == k)) begin
            mag = 1;
        end else if (k == 2) begin
            mag = 2;
        end else begin
            mag = 3;
        end
        return ((j % 2) != 0) ? -mag : mag;
    endfunction

endpackage

// File: rtl/mash_ddsm_cfg_efm_stage.sv
// One error-feedback accumulator stage: N-bit accumulator producing a carry.
// Inactive stages (above the selected order) hold zero and emit no carry.
module efm_stage #(
    parameter int P_WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_act,
    input  logic               i_clr,
    input  logic [P_WIDTH:0]   i_x,
    output logic [P_WIDTH-1:0] o_sum,
    output logic               o_carry
);

    logic [P_WIDTH-1:0] acc_q;
    logic [P_WIDTH-1:0] acc_d;
    logic [P_WIDTH:0]   sum_s;

    // Accumulate, producing the residue for the next stage and this stage's carry.
    always_comb begin
        sum_s   = {1'b0, acc_q} + i_x;
        acc_d   = acc_q;
        if (i_clr || !i_act) begin
            acc_d = {P_WIDTH{1'b0}};
        end else if (i_en) begin
            acc_d = sum_s[P_WIDTH-1:0];
        end else begin
            acc_d = acc_q;
        end
        o_sum   = i_act ? sum_s[P_WIDTH-1:0] : {P_WIDTH{1'b0}};
        o_carry = i_act & sum_s[P_WIDTH];
    end

    // Accumulator register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= {P_WIDTH{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mash_ddsm_cfg.sv
// Runtime-configurable MASH 1-1-..-1 delta-sigma modulator with optional
// 1-LSB LFSR dither. Drives the divider-ratio control of the fractional-N path.
module mash_ddsm_cfg
    import mash_ddsm_pkg::*;
#(
    parameter  int P_DATA_WIDTH = 16,
    parameter  int P_MAX_ORDER  = 4,
    localparam int P_OUT_WIDTH  = out_width(P_MAX_ORDER)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_load,
    input  logic [P_DATA_WIDTH-1:0] i_frac,
    input  logic [2:0]              i_order,
    input  logic                    i_dither_en,
    output logic [P_OUT_WIDTH-1:0]  o_y,
    output logic                    o_valid,
    output logic [P_MAX_ORDER-1:0]  o_carry
);

    // Depth of registered carry history (c[n-1] .. c[n-(MAX-1)]).
    localparam int HIST_D = (P_MAX_ORDER > 1) ? P_MAX_ORDER - 1 : 1;

    logic [P_DATA_WIDTH-1:0] frac_q,   frac_d;
    logic [2:0]              order_q,  order_d;
    logic                    dither_q, dither_d;
    logic [14:0]             lfsr_q,   lfsr_d;
    logic [2:0]              cnt_q,    cnt_d;
    logic [P_OUT_WIDTH-1:0]  y_q,      y_d;
    logic                    valid_q,  valid_d;
    logic [P_MAX_ORDER-1:0]  carry_q,  carry_d;
    logic [P_MAX_ORDER-1:0]  hist_q [HIST_D];
    logic [P_MAX_ORDER-1:0]  hist_d [HIST_D];

    logic [2:0]              order_new_s;
    logic                    order_chg_s;
    logic [P_DATA_WIDTH:0]   x_s;
    logic [P_MAX_ORDER-1:0]  carry_s;
    logic [P_MAX_ORDER-1:0]  win_s [P_MAX_ORDER];
    logic [2:0]              cnt_inc_s;
    int                      ncf_sum_s;

    // Load decode and stage-1 input with optional dither LSB.
    always_comb begin
        order_new_s = clamp_order(i_order, P_MAX_ORDER);
        order_chg_s = i_load && (order_new_s != order_q);
        x_s         = {1'b0, frac_q} + {{P_DATA_WIDTH{1'b0}}, dither_q & lfsr_q[0]};
    end

    // Stage chain: each stage integrates the residue of the one before it.
    for (genvar g = 0; g < P_MAX_ORDER; g++) begin : g_stage
        localparam logic [2:0] STAGE_IDX = 3'(g);
        logic [P_DATA_WIDTH:0]   x_in_s;
        logic [P_DATA_WIDTH-1:0] sum_s;
        logic                    c_s;

        if (g == 0) begin : g_first
            assign x_in_s = x_s;
        end else begin : g_chain
            assign x_in_s = {1'b0, g_stage[g-1].sum_s};
        end

        efm_stage #(.P_WIDTH(P_DATA_WIDTH)) u_stage (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (i_en),
            .i_act   (STAGE_IDX < order_q),
            .i_clr   (order_chg_s),
            .i_x     (x_in_s),
            .o_sum   (sum_s),
            .o_carry (c_s)
        );

        assign carry_s[g] = c_s;
    end

    // The final stage's residue has no consumer.
    logic unused_last_sum_s;
    assign unused_last_sum_s = ^g_stage[P_MAX_ORDER-1].sum_s;

    // Noise cancellation: stage k contributes the (k-1)-th backward difference of its carry.
    always_comb begin
        win_s[0] = carry_s;
        for (int t = 1; t < P_MAX_ORDER; t++) begin
            win_s[t] = hist_q[t-1];
        end
        ncf_sum_s = 0;
        for (int k = 0; k < P_MAX_ORDER; k++) begin
            for (int j = 0; j < P_MAX_ORDER; j++) begin
                ncf_sum_s = ncf_sum_s + ncf_coef(k, j) * int'(win_s[j][k]);
            end
        end
    end

    // Next-state for shadow registers, LFSR, carry history, settle counter and outputs.
    always_comb begin
        frac_d    = frac_q;
        order_d   = order_q;
        dither_d  = dither_q;
        lfsr_d    = lfsr_q;
        hist_d    = hist_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        valid_d   = valid_q;
        carry_d   = carry_q;
        cnt_inc_s = (cnt_q < order_q) ? cnt_q + 3'd1 : cnt_q;

        if (i_load) begin
            frac_d   = i_frac;
            order_d  = order_new_s;
            dither_d = i_dither_en;
        end else begin
            frac_d   = frac_q;
        end

        // The LFSR free-runs on enabled cycles even while a clear is in progress.
        if (i_en) begin
            lfsr_d = {lfsr_q[13:0], ^(lfsr_q & LFSR_TAPS)};
        end else begin
            lfsr_d = lfsr_q;
        end

        if (order_chg_s) begin
            for (int t = 0; t < HIST_D; t++) begin
                hist_d[t] = {P_MAX_ORDER{1'b0}};
            end
            cnt_d   = 3'd0;
            y_d     = {P_OUT_WIDTH{1'b0}};
            valid_d = 1'b0;
            carry_d = {P_MAX_ORDER{1'b0}};
        end else if (i_en) begin
            hist_d[0] = carry_s;
            for (int t = 1; t < HIST_D; t++) begin
                hist_d[t] = hist_q[t-1];
            end
            cnt_d   = cnt_inc_s;
            valid_d = (cnt_inc_s >= order_q);
            y_d     = P_OUT_WIDTH'(ncf_sum_s);
            carry_d = carry_s;
        end else begin
            cnt_d   = cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frac_q   <= {P_DATA_WIDTH{1'b0}};
            order_q  <= 3'(P_MAX_ORDER);
            dither_q <= 1'b0;
            lfsr_q   <= LFSR_SEED;
            cnt_q    <= 3'd0;
            y_q      <= {P_OUT_WIDTH{1'b0}};
            valid_q  <= 1'b0;
            carry_q  <= {P_MAX_ORDER{1'b0}};
            for (int t = 0; t < HIST_D; t++) begin
                hist_q[t] <= {P_MAX_ORDER{1'b0}};
            end
        end else begin
            frac_q   <= frac_d;
            order_q  <= order_d;
            dither_q <= dither_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            valid_q  <= valid_d;
            carry_q  <= carry_d;
            for (int t = 0; t < HIST_D; t++) begin
                hist_q[t] <= hist_d[t];
            end
        end
    end

    assign o_y     = y_q;
    assign o_valid = valid_q;
    assign o_carry = carry_q;

endmodule

// File: tb/tb_mash_ddsm_cfg.sv
// Directed self-checking bench for mash_ddsm_cfg (N=8, max order 4).
module tb_mash_ddsm_cfg;

    localparam int N  = 8;
    localparam int MO = 4;
    localparam int OW = MO + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          load;
    logic [N-1:0]  frac;
    logic [2:0]    ord;
    logic          dith;
    logic [OW-1:0] y;
    logic          valid;
    logic [MO-1:0] carry;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Reference model state
    int          m_acc [4];
    int          m_h   [4][4];   // m_h[k][d]: carry of stage k, d enabled cycles ago
    int          m_car [4];
    int          m_frac, m_order, m_dith, m_y, m_cnt, m_valid;
    logic [14:0] m_lfsr;

    mash_ddsm_cfg #(.P_DATA_WIDTH(N), .P_MAX_ORDER(MO)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_load      (load),
        .i_frac      (frac),
        .i_order     (ord),
        .i_dither_en (dith),
        .o_y         (y),
        .o_valid     (valid),
        .o_carry     (carry)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks_cnt++;
        if (obs != exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_acc[k] = 0;
            m_car[k] = 0;
            for (int d = 0; d < 4; d++) m_h[k][d] = 0;
        end
        m_frac = 0; m_order = MO; m_dith = 0; m_y = 0; m_cnt = 0; m_valid = 0;
        m_lfsr = 15'h0001;
    endtask

    task automatic lfsr_adv();
        m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
    endtask

    // One clock edge of the reference model, using the inputs currently driven.
    task automatic model_step();
        int newo, x, prev, t;
        int c [4];
        newo = (ord == 3'd0) ? 1 : ((int'(ord) > MO) ? MO : int'(ord));
        if (load && newo != m_order) begin
            for (int k = 0; k < 4; k++) begin
                m_acc[k] = 0;
                m_car[k] = 0;
                for (int d = 0; d < 4; d++) m_h[k][d] = 0;
            end
            m_cnt = 0; m_valid = 0; m_y = 0;
            if (en) lfsr_adv();
        end else if (en) begin
            x    = m_frac + ((m_dith != 0 && m_lfsr[0]) ? 1 : 0);
            prev = x;
            for (int k = 0; k < 4; k++) begin
                if (k < m_order) begin
                    t        = m_acc[k] + prev;
                    c[k]     = t >> N;
                    m_acc[k] = t % (1 << N);
                    prev     = m_acc[k];
                end else begin
                    c[k]     = 0;
                    m_acc[k] = 0;
                end
            end
            m_y = c[0] + (c[1] - m_h[1][1])
                + (c[2] - 2 * m_h[2][1] + m_h[2][2])
                + (c[3] - 3 * m_h[3][1] + 3 * m_h[3][2] - m_h[3][3]);
            for (int k = 0; k < 4; k++) begin
                m_h[k][3] = m_h[k][2];
                m_h[k][2] = m_h[k][1];
                m_h[k][1] = c[k];
                m_car[k]  = c[k];
            end
            if (m_cnt < m_order) m_cnt++;
            m_valid = (m_cnt >= m_order) ? 1 : 0;
            lfsr_adv();
        end
        if (load) begin
            m_frac  = int'(frac);
            m_order = newo;
            m_dith  = int'(dith);
        end
    endtask

    // Advance one clock with the model and optionally compare all outputs.
    task automatic cyc(input string tag, input bit cmp);
        model_step();
        @(posedge clk);
        #1;
        if (cmp) begin
            check_val({tag, "_y"}, int'($signed(y)), m_y);
            check_val({tag, "_carry"}, int'(carry),
                      m_car[0] + 2 * m_car[1] + 4 * m_car[2] + 8 * m_car[3]);
            check_val({tag, "_valid"}, int'(valid), m_valid);
        end
    endtask

    initial begin
        int sum, bad, yv, found;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; frac = 8'd0; ord = 3'd0; dith = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // 1. reset state
        check_val("rst_y", int'(y), 0);
        check_val("rst_valid", int'(valid), 0);
        check_val("rst_carry", int'(carry), 0);
        check_val("rst_lfsr", int'(dut.lfsr_q), 1);
        check_val("rst_order", int'(dut.order_q), 4);
        rst_n = 1'b1;
        en    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc("t1", 1'b1);
            check_val("t1_valid_hand", int'(valid), (i >= 3) ? 1 : 0);
            check_val("t1_y_hand", int'(y), 0);
        end

        // 2. order 1, frac 64
        en = 1'b0; load = 1'b1; ord = 3'd1; frac = 8'd64; dith = 1'b0;
        cyc("t2_load", 1'b1);
        load = 1'b0; en = 1'b1;
        sum = 0;
        for (int i = 0; i < 256; i++) begin
            cyc("t2", 1'b1);
            if (i < 8) check_val("t2_seq", int'($signed(y)), (i % 4 == 3) ? 1 : 0);
            sum += int'($signed(y));
        end
        check_val("t2_sum", sum, 64);

        // 3. order 4, frac 255
        en = 1'b0; load = 1'b1; ord = 3'd4; frac = 8'd255;
        cyc("t3_load", 1'b1);
        load = 1'b0; en = 1'b1;
        sum = 0; bad = 0;
        for (int i = 0; i < 256; i++) begin
            cyc("t3", 1'b1);
            yv = int'($signed(y));
            sum += yv;
            if (yv < -7 || yv > 8) bad++;
        end
        check_val("t3_range_violations", bad, 0);
        check_val("t3_sum_within_7", ((sum - 255) <= 7 && (255 - sum) <= 7) ? 1 : 0, 1);
        // frac 0 from a cleared start
        en = 1'b0; load = 1'b1; ord = 3'd1; frac = 8'd0;
        cyc("t3_clr1", 1'b0);
        ord = 3'd4;
        cyc("t3_clr4", 1'b0);
        load = 1'b0; en = 1'b1;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            cyc("t3z", 1'b0);
            if (y != '0) bad++;
        end
        check_val("t3_zero_count", bad, 0);

        // 4. order 2, frac 100, enable gap
        en = 1'b0; load = 1'b1; ord = 3'd2; frac = 8'd100;
        cyc("t4_load", 1'b1);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 20; i++) cyc("t4a", 1'b1);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc("t4_gap", 1'b1);
            check_val("t4_lfsr_hold", int'(dut.lfsr_q), int'(m_lfsr));
        end
        en = 1'b1;
        for (int i = 0; i < 30; i++) cyc("t4b", 1'b1);

        // 5. order 1 running, then load order 3 on an enabled edge
        load = 1'b1; ord = 3'd1; frac = 8'd77;
        cyc("t5_load1", 1'b1);
        load = 1'b0;
        for (int i = 0; i < 10; i++) cyc("t5a", 1'b1);
        load = 1'b1; ord = 3'd3;
        cyc("t5_load3", 1'b1);
        check_val("t5_clr_y", int'(y), 0);
        check_val("t5_clr_valid", int'(valid), 0);
        load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc("t5b", 1'b1);
            if (i < 4) check_val("t5_valid_hand", int'(valid), (i >= 2) ? 1 : 0);
        end
        en = 1'b0; load = 1'b1; ord = 3'd7;
        cyc("t5_load7", 1'b1);
        check_val("t5_order_clamp", int'(dut.order_q), 4);

        // 6. dither on, order 1, frac 0
        load = 1'b1; ord = 3'd1; frac = 8'd0; dith = 1'b1;
        cyc("t6_load", 1'b1);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 100; i++) cyc("t6", 1'b1);
        // raise frac so a non-zero sample appears, then reset between edges
        load = 1'b1; frac = 8'd200;
        cyc("t6_load2", 1'b1);
        load = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            cyc("t6b", 1'b1);
            if (m_y == 1 && m_valid == 1) found = 1;
        end
        check_val("t6_found_nonzero", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_async_y", int'(y), 0);
        check_val("t6_async_valid", int'(valid), 0);
        check_val("t6_async_carry", int'(carry), 0);
        check_val("t6_async_lfsr", int'(dut.lfsr_q), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
